// File: rtl/mips_pkg.sv
// ============================================================================
// Package     : mips_pkg
// Description : Opcodes, register constants and hazard FSM state type shared by
//               the MIPS core's controlUnit and hazard_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_t;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// Module      : load_use_detect
// Description : Combinational lw load-use compare between the instruction in
//               EX (shadowed memRead/rt) and the source fields of the one in ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect
    import mips_pkg::*;
(
    input  logic       exMemRead,
    input  logic [4:0] exRt,
    input  logic [4:0] idRs,
    input  logic [4:0] idRt,
    input  logic [5:0] idOpCode,
    output logic       loadUse
);

    logic rt_is_source;

    // rt is read as a source only by R-type, sw (store data) and beq
    assign rt_is_source = (idOpCode == OP_RTYPE) || (idOpCode == OP_SW) || (idOpCode == OP_BEQ);

    assign loadUse = exMemRead && (exRt != REG_ZERO) &&
                     ((exRt == idRs) || ((exRt == idRt) && rt_is_source));

endmodule

`default_nettype wire

// File: rtl/hazard_controller.sv
// ============================================================================
// Module      : hazard_controller
// Description : 5-stage pipeline sequencer: load-use stall, taken-beq flush and
//               memory-busy freeze with watchdog. Optional perf counters are
//               built when HAZARD_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_controller
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W       = 32
`endif
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       idOpCode,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             branchTaken,
    input  logic             memBusy,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             idExWrite,
    output logic             exMemWrite,
    output logic             ifIdFlush,
    output logic             idExFlush,
    output logic             exMemFlush,
    output logic             stallSignal,
    output logic             memTimeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt,
    output logic [CNT_W-1:0] waitCnt_total
`endif
);

    localparam int              WCNT_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_VAL = WCNT_W'(MEM_TIMEOUT);

    hz_state_t         state;
    logic [WCNT_W-1:0] wait_cnt;
    logic [WCNT_W-1:0] wait_cnt_next;
    logic              ex_mem_read;
    logic [4:0]        ex_rt;
    logic              load_use;

    load_use_detect u_load_use_detect (
        .exMemRead (ex_mem_read),
        .exRt      (ex_rt),
        .idRs      (idRs),
        .idRt      (idRt),
        .idOpCode  (idOpCode),
        .loadUse   (load_use)
    );

    // First busy cycle of a wait counts as 1; afterwards saturate at the limit
    always_comb begin
        wait_cnt_next = wait_cnt;
        if (state == HZ_RUN) begin
            wait_cnt_next = WCNT_W'(1);
        end else if (wait_cnt != TIMEOUT_VAL) begin
            wait_cnt_next = wait_cnt + WCNT_W'(1);
        end
    end

    always_comb begin
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        idExWrite   = 1'b1;
        exMemWrite  = 1'b1;
        ifIdFlush   = 1'b0;
        idExFlush   = 1'b0;
        exMemFlush  = 1'b0;
        stallSignal = 1'b0;
        memTimeout  = 1'b0;
        if (reset) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            idExWrite   = 1'b0;
            exMemWrite  = 1'b0;
            stallSignal = 1'b1;
        end else if (memBusy) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            memTimeout = (wait_cnt_next == TIMEOUT_VAL) && (wait_cnt != TIMEOUT_VAL);
        end else if (branchTaken) begin
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
            exMemFlush = 1'b1;
        end else if (load_use) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            stallSignal = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HZ_RUN;
            wait_cnt    <= '0;
            ex_mem_read <= 1'b0;
            ex_rt       <= REG_ZERO;
        end else begin
            if (memBusy) begin
                state    <= HZ_MEM_WAIT;
                wait_cnt <= wait_cnt_next;
            end else begin
                state    <= HZ_RUN;
                wait_cnt <= '0;
            end
            // Shadow tracks what actually lands in ID/EX, so bubbles and flushes read as no-load
            if (idExWrite) begin
                ex_mem_read <= (idOpCode == OP_LW) && !stallSignal && !idExFlush;
                ex_rt       <= idRt;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCnt      <= '0;
            flushCnt      <= '0;
            waitCnt_total <= '0;
        end else begin
            if (memBusy) begin
                waitCnt_total <= waitCnt_total + CNT_W'(1);
            end else if (branchTaken) begin
                flushCnt <= flushCnt + CNT_W'(1);
            end else if (load_use) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// ============================================================================
// Module      : tb_hazard_controller
// Description : Scoreboard bench for hazard_controller: directed scenarios then
//               random traffic checked against an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_controller;

    localparam int MT = 4;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic f_ifid;
        logic f_idex;
        logic f_exmem;
        logic stall;
        logic tmo;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] idOpCode;
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic       branchTaken;
    logic       memBusy;
    logic       pcWrite, ifIdWrite, idExWrite, exMemWrite;
    logic       ifIdFlush, idExFlush, exMemFlush, stallSignal, memTimeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallCnt, flushCnt, waitCnt_total;
`endif

    hazard_controller #(.MEM_TIMEOUT(MT)) dut (
        .clk         (clk),
        .reset       (reset),
        .idOpCode    (idOpCode),
        .idRs        (idRs),
        .idRt        (idRt),
        .branchTaken (branchTaken),
        .memBusy     (memBusy),
        .pcWrite     (pcWrite),
        .ifIdWrite   (ifIdWrite),
        .idExWrite   (idExWrite),
        .exMemWrite  (exMemWrite),
        .ifIdFlush   (ifIdFlush),
        .idExFlush   (idExFlush),
        .exMemFlush  (exMemFlush),
        .stallSignal (stallSignal),
        .memTimeout  (memTimeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stallCnt      (stallCnt),
        .flushCnt      (flushCnt),
        .waitCnt_total (waitCnt_total)
`endif
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   drive_done = 0;

    // Model: what instruction sits in EX, and how long the current freeze has lasted
    bit       m_ex_is_lw = 0;
    bit [4:0] m_ex_dst   = 0;
    int       m_freeze   = 0;

    task automatic step(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic br, input logic busy, input logic rst);
        exp_t e;
        bit   reads_rt;
        bit   dep;
        @(negedge clk);
        idOpCode    = op;
        idRs        = rs;
        idRt        = rt;
        branchTaken = br;
        memBusy     = busy;
        reset       = rst;
        reads_rt = (op == 6'd0) || (op == 6'd43) || (op == 6'd4);
        dep = m_ex_is_lw && (m_ex_dst != 5'd0) &&
              ((m_ex_dst == rs) || (reads_rt && m_ex_dst == rt));
        e = '{pc:1, ifid:1, idex:1, exmem:1, f_ifid:0, f_idex:0, f_exmem:0, stall:0, tmo:0};
        if (rst) begin
            e = '{pc:0, ifid:0, idex:0, exmem:0, f_ifid:0, f_idex:0, f_exmem:0, stall:1, tmo:0};
            m_ex_is_lw = 0;
            m_ex_dst   = 0;
            m_freeze   = 0;
        end else if (busy) begin
            m_freeze = m_freeze + 1;
            e = '{pc:0, ifid:0, idex:0, exmem:0, f_ifid:0, f_idex:0, f_exmem:0, stall:0,
                  tmo:(m_freeze == MT)};
        end else begin
            m_freeze = 0;
            if (br) begin
                e.f_ifid = 1; e.f_idex = 1; e.f_exmem = 1;
                m_ex_is_lw = 0;
            end else if (dep) begin
                e.pc = 0; e.ifid = 0; e.stall = 1;
                m_ex_is_lw = 0;
            end else begin
                m_ex_is_lw = (op == 6'd35);
                m_ex_dst   = rt;
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: samples each cycle 3 time units before the rising edge
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{pcWrite, ifIdWrite, idExWrite, exMemWrite, ifIdFlush, idExFlush,
                      exMemFlush, stallSignal, memTimeout};
                n_vec = n_vec + 1;
                if (a !== e) begin
                    n_fail = n_fail + 1;
                    $display("FAIL outputs vec %0d t=%0t: got %b required %b (pc,ifid,idex,exmem,fl_ifid,fl_idex,fl_exmem,stall,tmo)",
                             n_vec, $time, a, e);
                end
            end
        end
    end

    initial begin
        int ops[5];
        int busy_left;
        ops = '{0, 35, 43, 4, 8};
        reset = 1'b1; idOpCode = 0; idRs = 0; idRt = 0; branchTaken = 0; memBusy = 0;

        // reset state
        step(6'd0, 5'd0, 5'd0, 0, 0, 1);
        step(6'd0, 5'd0, 5'd0, 0, 0, 1);
        // load-use: lw rt=5 then add rs=5 -> one bubble
        step(6'd35, 5'd1, 5'd5, 0, 0, 0);
        step(6'd0,  5'd5, 5'd2, 0, 0, 0);
        step(6'd0,  5'd5, 5'd2, 0, 0, 0);
        // no false stall: rt=0, and lw whose rt matches but is not a source
        step(6'd35, 5'd1, 5'd0, 0, 0, 0);
        step(6'd0,  5'd0, 5'd0, 0, 0, 0);
        step(6'd35, 5'd1, 5'd5, 0, 0, 0);
        step(6'd35, 5'd2, 5'd5, 0, 0, 0);
        // sw reads rt: must stall on the preceding lw rt=5
        step(6'd43, 5'd3, 5'd5, 0, 0, 0);
        step(6'd43, 5'd3, 5'd5, 0, 0, 0);
        // branch beats load-use, shadow cleared afterwards
        step(6'd35, 5'd1, 5'd7, 0, 0, 0);
        step(6'd0,  5'd7, 5'd7, 1, 0, 0);
        step(6'd0,  5'd7, 5'd7, 0, 0, 0);
        // freeze 3 cycles with a held branch acting on release
        step(6'd0, 5'd1, 5'd2, 1, 1, 0);
        step(6'd0, 5'd1, 5'd2, 1, 1, 0);
        step(6'd0, 5'd1, 5'd2, 1, 1, 0);
        step(6'd0, 5'd1, 5'd2, 1, 0, 0);
        step(6'd0, 5'd1, 5'd2, 0, 0, 0);
        // watchdog: 10 busy cycles, single pulse on the 4th
        for (int i = 0; i < 10; i++) step(6'd8, 5'd1, 5'd2, 0, 1, 0);
        step(6'd8, 5'd1, 5'd2, 0, 0, 0);
        // load pending in EX, then reset in the middle of a freeze
        step(6'd35, 5'd1, 5'd9, 0, 0, 0);
        step(6'd0,  5'd1, 5'd2, 0, 1, 0);
        step(6'd0,  5'd1, 5'd2, 0, 1, 0);
        step(6'd0,  5'd9, 5'd2, 0, 1, 1);
        step(6'd0,  5'd9, 5'd2, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(6'd0, 5'd1, 5'd2, 0, 1, 0);

        // random traffic
        busy_left = 0;
        for (int i = 0; i < 600; i++) begin
            logic [5:0] op;
            logic [4:0] rs, rt;
            logic       br, bz, rs_t;
            op = 6'(ops[$urandom_range(0, 4)]);
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            br = ($urandom_range(0, 9) == 0);
            if (busy_left == 0 && $urandom_range(0, 9) == 0) busy_left = $urandom_range(1, 7);
            bz = (busy_left > 0);
            if (busy_left > 0) busy_left = busy_left - 1;
            rs_t = ($urandom_range(0, 49) == 0);
            step(op, rs, rt, br, bz, rs_t);
        end
        drive_done = 1;
    end

    initial begin
        wait (drive_done);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #5;
        if (exp_q.size() > 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d expected vectors never compared, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish by t=%0t", $time);
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
